// File: rtl/mp64_sram_dp_be.sv
// True dual-port synchronous SRAM with byte enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear sweep.
module mp64_sram_dp_be #(
  parameter int unsigned       ADDR_W     = 4,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       OUT_REG    = 0,
  parameter int unsigned       RDW_MODE   = 0,
  parameter int unsigned       INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_ce,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_ce,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  init_busy,
  output logic                  coll
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {CLEAR, READY} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_c;

  logic              a_ce_eff, b_ce_eff, a_wr, b_wr, same_addr;
  logic [DATA_W-1:0] old_a, old_b, merged_a, merged_b;
  logic [DATA_W-1:0] a_q1, b_q1;

  // Byte-lane merge of both ports' writes onto a word; port A wins shared lanes.
  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old,
    input logic              hit_a,
    input logic              hit_b,
    input logic [BE_W-1:0]   be_a,
    input logic [BE_W-1:0]   be_b,
    input logic [DATA_W-1:0] wd_a,
    input logic [DATA_W-1:0] wd_b
  );
    logic [DATA_W-1:0] w;
    w = old;
    for (int k = 0; k < int'(BE_W); k++) begin
      if (hit_a && be_a[k])      w[8*k +: 8] = wd_a[8*k +: 8];
      else if (hit_b && be_b[k]) w[8*k +: 8] = wd_b[8*k +: 8];
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_c   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_c = 1'b1;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == CLEAR);

  always_comb begin
    a_ce_eff  = a_ce & ~init_busy;
    b_ce_eff  = b_ce & ~init_busy;
    a_wr      = a_ce_eff & a_we;
    b_wr      = b_ce_eff & b_we;
    same_addr = (a_addr == b_addr);
    old_a     = mem[a_addr];
    old_b     = mem[b_addr];
    merged_a  = merge_word(old_a, a_wr, b_wr & same_addr, a_be, b_be, a_wdata, b_wdata);
    merged_b  = merge_word(old_b, a_wr & same_addr, b_wr, a_be, b_be, a_wdata, b_wdata);
  end

  // Array has no reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      if (a_wr) mem[a_addr] <= merged_a;
      if (b_wr) mem[b_addr] <= merged_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q1 <= '0;
      b_q1 <= '0;
      coll <= 1'b0;
    end else begin
      if (a_ce_eff) a_q1 <= (RDW_MODE != 0) ? merged_a : old_a;
      if (b_ce_eff) b_q1 <= (RDW_MODE != 0) ? merged_b : old_b;
      coll <= a_wr & b_wr & same_addr & (|(a_be & b_be));
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              a_v1, b_v1;
      logic [DATA_W-1:0] a_q2, b_q2;

      // Second stage advances only behind a valid first-stage read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_v1 <= 1'b0;
          b_v1 <= 1'b0;
          a_q2 <= '0;
          b_q2 <= '0;
        end else begin
          a_v1 <= a_ce_eff;
          b_v1 <= b_ce_eff;
          if (a_v1) a_q2 <= a_q1;
          if (b_v1) b_q2 <= b_q1;
        end
      end

      assign a_rdata = a_q2;
      assign b_rdata = b_q2;
    end else begin : g_noreg
      assign a_rdata = a_q1;
      assign b_rdata = b_q1;
    end
  endgenerate

endmodule

// File: tb/tb_mp64_sram_dp_be.sv
// Directed bench for mp64_sram_dp_be: three instances (read-first, write-first,
// read-first with output register) share one stimulus stream.
module tb_mp64_sram_dp_be;

  localparam logic [63:0] IV = 64'h5A5A_5A5A_5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_ce, a_we, b_ce, b_we;
  logic [7:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;

  logic [63:0] ra0, rb0, ra1, rb1, ra2, rb2;
  logic        busy0, busy1, busy2, coll0, coll1, coll2;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mp64_sram_dp_be #(.ADDR_W(4), .DATA_W(64), .OUT_REG(0), .RDW_MODE(0),
                    .INIT_CLEAR(1), .INIT_VAL(IV)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_ce(a_ce), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ra0),
    .b_ce(b_ce), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rb0),
    .init_busy(busy0), .coll(coll0));

  mp64_sram_dp_be #(.ADDR_W(4), .DATA_W(64), .OUT_REG(0), .RDW_MODE(1),
                    .INIT_CLEAR(1), .INIT_VAL(IV)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_ce(a_ce), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ra1),
    .b_ce(b_ce), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rb1),
    .init_busy(busy1), .coll(coll1));

  mp64_sram_dp_be #(.ADDR_W(4), .DATA_W(64), .OUT_REG(1), .RDW_MODE(0),
                    .INIT_CLEAR(1), .INIT_VAL(IV)) u2 (
    .clk(clk), .rst_n(rst_n),
    .a_ce(a_ce), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ra2),
    .b_ce(b_ce), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rb2),
    .init_busy(busy2), .coll(coll2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic ce, input logic we, input logic [7:0] be,
                       input logic [3:0] addr, input logic [63:0] wd);
    a_ce = ce; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drv_b(input logic ce, input logic we, input logic [7:0] be,
                       input logic [3:0] addr, input logic [63:0] wd);
    b_ce = ce; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
  endtask

  task automatic idle();
    drv_a(1'b0, 1'b0, 8'h00, 4'h0, 64'h0);
    drv_b(1'b0, 1'b0, 8'h00, 4'h0, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_ra0", ra0, 64'h0);
    chk("rst_rb2", rb2, 64'h0);
    chk("rst_coll", 64'(coll0), 64'd0);
    tick();
    rst_n = 1'b1;

    // Sweep length, with port activity that must be ignored while busy
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) begin
        drv_a(1'b1, 1'b1, 8'hFF, 4'h0, 64'h0);
        drv_b(1'b1, 1'b1, 8'hFF, 4'h0, 64'h0);
      end
      if (i == 6) idle();
      tick();
      chk("sweep_busy", 64'(busy0), (i < 16) ? 64'd1 : 64'd0);
    end
    chk("sweep_ra0", ra0, 64'h0);
    chk("sweep_coll", 64'(coll0), 64'd0);

    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 1'b0, 8'h00, 4'(i), 64'h0);
      drv_b(1'b1, 1'b0, 8'h00, 4'(15 - i), 64'h0);
      tick();
      chk("init_rd_a", ra0, IV);
      chk("init_rd_b", rb0, IV);
    end
    idle();
    tick();
    chk("init_rd_a_oreg", ra2, IV);

    // Byte-enable partial write
    drv_a(1'b1, 1'b1, 8'hFF, 4'd3, 64'h1111_2222_3333_4444);
    tick();
    chk("be_full_rf", ra0, IV);
    chk("be_full_wf", ra1, 64'h1111_2222_3333_4444);
    drv_a(1'b1, 1'b1, 8'h0F, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("be_part_rf", ra0, 64'h1111_2222_3333_4444);
    chk("be_part_wf", ra1, 64'h1111_2222_FFFF_FFFF);
    idle();
    drv_b(1'b1, 1'b0, 8'h00, 4'd3, 64'h0);
    tick();
    chk("be_readback", rb0, 64'h1111_2222_FFFF_FFFF);

    // Cross-port read during write at address 7
    idle();
    drv_a(1'b1, 1'b1, 8'hFF, 4'd7, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    drv_a(1'b1, 1'b1, 8'hFF, 4'd7, 64'h5555_5555_5555_5555);
    drv_b(1'b1, 1'b0, 8'h00, 4'd7, 64'h0);
    tick();
    chk("rdw_b_rf", rb0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rdw_a_rf", ra0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rdw_b_wf", rb1, 64'h5555_5555_5555_5555);
    chk("rdw_a_wf", ra1, 64'h5555_5555_5555_5555);
    idle();
    tick();
    chk("rdw_a_oreg", ra2, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rdw_b_oreg", rb2, 64'hAAAA_AAAA_AAAA_AAAA);

    // Dual write to address 9 with overlapping lanes
    drv_a(1'b1, 1'b1, 8'hFF, 4'd9, 64'h0123_4567_89AB_CDEF);
    tick();
    drv_a(1'b1, 1'b1, 8'hF0, 4'd9, 64'h1111_1111_1111_1111);
    drv_b(1'b1, 1'b1, 8'h3C, 4'd9, 64'h2222_2222_2222_2222);
    tick();
    chk("coll_set", 64'(coll0), 64'd1);
    chk("dual_a_rf", ra0, 64'h0123_4567_89AB_CDEF);
    chk("dual_a_wf", ra1, 64'h1111_1111_2222_CDEF);
    chk("dual_b_wf", rb1, 64'h1111_1111_2222_CDEF);
    idle();
    drv_a(1'b1, 1'b0, 8'h00, 4'd9, 64'h0);
    tick();
    chk("coll_clear", 64'(coll0), 64'd0);
    chk("dual_readback", ra0, 64'h1111_1111_2222_CDEF);

    // Dual write, same address, disjoint lanes
    drv_a(1'b1, 1'b1, 8'h0F, 4'd9, 64'h3333_3333_3333_3333);
    drv_b(1'b1, 1'b1, 8'hF0, 4'd9, 64'h4444_4444_4444_4444);
    tick();
    chk("disj_coll", 64'(coll0), 64'd0);
    chk("disj_a_wf", ra1, 64'h4444_4444_3333_3333);

    // Dual write, different addresses
    drv_a(1'b1, 1'b1, 8'hFF, 4'd1, 64'hA1A1_0000_1111_A1A1);
    drv_b(1'b1, 1'b1, 8'hFF, 4'd2, 64'hB2B2_0000_2222_B2B2);
    tick();
    chk("diff_coll", 64'(coll0), 64'd0);
    drv_a(1'b1, 1'b0, 8'h00, 4'd1, 64'h0);
    drv_b(1'b1, 1'b0, 8'h00, 4'd2, 64'h0);
    tick();
    chk("diff_rd_a", ra0, 64'hA1A1_0000_1111_A1A1);
    chk("diff_rd_b", rb0, 64'hB2B2_0000_2222_B2B2);
    idle();
    tick();
    chk("diff_oreg_a", ra2, 64'hA1A1_0000_1111_A1A1);
    chk("diff_oreg_b", rb2, 64'hB2B2_0000_2222_B2B2);

    // Output-register latency and hold
    drv_a(1'b1, 1'b1, 8'hFF, 4'd5, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    idle();
    tick();
    drv_a(1'b1, 1'b0, 8'h00, 4'd5, 64'h0);
    drv_b(1'b1, 1'b0, 8'h00, 4'd3, 64'h0);
    tick();
    chk("oreg_lat1", ra2, IV);
    chk("noreg_lat1", ra0, 64'hDEAD_BEEF_0BAD_F00D);
    idle();
    tick();
    chk("oreg_lat2_a", ra2, 64'hDEAD_BEEF_0BAD_F00D);
    chk("oreg_lat2_b", rb2, 64'h1111_2222_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_oreg_a", ra2, 64'hDEAD_BEEF_0BAD_F00D);
      chk("hold_oreg_b", rb2, 64'h1111_2222_FFFF_FFFF);
      chk("hold_noreg_a", ra0, 64'hDEAD_BEEF_0BAD_F00D);
    end

    // Asynchronous reset, then reset again mid-sweep
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ra0", ra0, 64'h0);
    chk("arst_ra2", ra2, 64'h0);
    chk("arst_busy", 64'(busy0), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy0), 64'd1);
    chk("mid_rb0", rb0, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("resweep_busy", 64'(busy0), (i < 16) ? 64'd1 : 64'd0);
    end
    drv_a(1'b1, 1'b0, 8'h00, 4'd5, 64'h0);
    drv_b(1'b1, 1'b0, 8'h00, 4'd9, 64'h0);
    tick();
    chk("resweep_rd_a", ra0, IV);
    chk("resweep_rd_b", rb0, IV);
    idle();
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mp64_sram_dp_be.md
Name: mp64_sram_dp_be

Overview:
- Parametrised true dual-port synchronous SRAM with per-byte write enables and selectable read-during-write (RDW) semantics.
- Optional output register.
- Built-in post-reset clear sequencer that initialises the array before the ports go live.
- Successor to the single-port SRAM macro. Used for shared buffers between two masters, e.g. a DMA engine and the CPU side.

Parameters:
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- DATA_W, 64: word width. Must be a multiple of 8.
- BE_W, DATA_W/8: byte-enable width. Derived; not to be overridden.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.
- RDW_MODE, 0: 0 is read-first (old data); 1 is write-first (new merged data). Applies same-port and cross-port.
- INIT_CLEAR, 1: 1 runs the clear sequencer after reset; 0 leaves the array uninitialised and the ports live immediately.
- INIT_VAL, 0: DATA_W-wide word written to every location by the sequencer.

Ports:
- clk  in  1  clock; all activity on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_ce  in  1  port A enable.
- a_we  in  1  port A write (only when a_ce=1).
- a_be  in  BE_W  port A byte enables.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data.
- b_ce, b_we, b_be, b_addr, b_wdata, b_rdata: same as port A, for port B.
- init_busy  out  1  high while the clear sequencer runs. Ports are ignored while high.
- coll  out  1  registered 1-cycle pulse: both ports wrote one or more common byte lanes of the same address in the previous cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_rdata=0, b_rdata=0, coll=0, pipeline valid flags=0.
  - init_busy=INIT_CLEAR. The sequencer is forced to state CLEAR with counter=0.
  - Array contents are not reset.
- Sequencer FSM, states CLEAR and READY:
  - CLEAR: each posedge writes INIT_VAL to address counter, then counter++. On the posedge writing DEPTH-1 → READY; init_busy falls after that edge. CLEAR takes exactly DEPTH cycles after rst_n rises.
  - READY: terminal state until the next reset.
  - INIT_CLEAR=0: reset lands in READY.
  - Reset asserted mid-CLEAR: counter returns to 0 and the sweep restarts from 0 after release.
- While init_busy=1:
  - a_ce and b_ce are treated as 0.
  - rdata holds 0 and coll stays 0.
- Write: on posedge with x_ce & x_we, byte lane k of mem[x_addr] takes x_wdata lane k iff x_be[k]. Lanes with be=0 are untouched.
- Read (ce=1, we=0):
  - OUT_REG=0: x_rdata = mem[x_addr] immediately after the posedge sampling ce.
  - OUT_REG=1: the value appears one posedge later.
  - The output register loads only when the stage-1 read was valid.
- ce=0: x_rdata holds its last value indefinitely, at both stages.
- Write cycle on a port also drives that port's rdata:
  - RDW_MODE=0: pre-write word.
  - RDW_MODE=1: post-write merged word. Unenabled lanes come from old data.
- Cross-port, same address, same cycle, one port writing and the other reading:
  - The reader returns old data (RDW_MODE=0) or the merged new word (RDW_MODE=1).
  - The merged word includes both ports' writes if both are writing.
- Both ports write the same address:
  - Per lane, port A wins where both be bits are set.
  - Lanes enabled on only one port take that port's data.
  - coll=1 on the next cycle iff (a_be & b_be)!=0. Otherwise coll=0.
- Both ports write different addresses: both writes complete and coll=0.
- Address wrap: none. Addresses are exact, with no aliasing beyond ADDR_W.

Test Plan:
- ADDR_W=4, INIT_VAL=64'h5A5A_5A5A_5A5A_5A5A → init_busy high 16 cycles after rst_n rises; read of all 16 addresses then returns 5A5A…; a_ce pulsed during CLEAR has no effect.
- Write 64'h1111_2222_3333_4444 to addr 3, then port A write addr 3 with a_be=8'h0F and data 64'hFFFF_FFFF_FFFF_FFFF → read gives 64'h1111_2222_FFFF_FFFF.
- Same address 7 holding 0xAA…A: A writes 0x55…5 (be=FF) while B reads → b_rdata=0xAA…A when RDW_MODE=0, 0x55…5 when RDW_MODE=1. A's own rdata follows the same rule.
- Both write addr 9: A be=8'hF0 data all 0x11, B be=8'h3C data all 0x22 → mem[9]=64'h1111_1111_2222_xxxx (lanes 1:0 unchanged); coll=1 for exactly one cycle. Repeat with disjoint be → coll=0.
- OUT_REG=1: read addr 5 → data appears 2 posedges after ce sampled; ce dropped → both rdata hold over 4 idle cycles.
- Assert rst_n=0 at cycle 6 of CLEAR → rdata=0 and init_busy=1 immediately (asynchronous); after release the full 16-cycle sweep reruns from address 0.
